// File: rtl/sdram_cmd_sched.sv
// Per-access SDRAM command scheduler with periodic refresh ownership.
// Optional closed-page policy: define SDRAM_AUTO_PRECHARGE_EN.
module sdram_cmd_sched #(
    parameter int SDRAM_T_RP_PS    = 20000,
    parameter int SDRAM_T_RCD_PS   = 20000,
    parameter int SDRAM_T_RFC_PS   = 66000,
    parameter int SDRAM_T_REFI_PS  = 7800000,
    parameter int SYSCLK_PERIOD_PS = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_bank,
    input  logic [12:0] req_row,
    input  logic [8:0]  req_col,
    input  logic        req_write,
    input  logic        row_active,
    input  logic        row_addr_match,
    input  logic        tras_done,
    input  logic        tras_all_done,
    input  logic        trc_done,
    output logic [1:0]  sdram_bank_addr,
    output logic [12:0] sdram_row_addr,
    output logic [8:0]  sdram_col_addr,
    output logic        sdram_ap,
    output logic [2:0]  cmd,
    output logic        precharge_row,
    output logic        precharge_all,
    output logic        activate_row,
    output logic        access_done
);
    localparam int RP_CYC   = (SDRAM_T_RP_PS   + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int RCD_CYC  = (SDRAM_T_RCD_PS  + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int RFC_CYC  = (SDRAM_T_RFC_PS  + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int REFI_CYC = (SDRAM_T_REFI_PS + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int WW = $clog2(RP_CYC + RCD_CYC + RFC_CYC + 1);
    localparam int RW = $clog2(REFI_CYC);

    localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_PRE = 3'd2, CMD_PREALL = 3'd3,
                           CMD_READ = 3'd4, CMD_WRITE = 3'd5, CMD_REFRESH = 3'd6;

    typedef enum logic [2:0] {
        IDLE, CHECK, TRP_WAIT, TRCD_WAIT, REF_PREALL, REF_TRP, REF_TRFC
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          ref_pending_q, ref_pending_d;
    logic          ret_idle_q, ret_idle_d;
    logic [1:0]    bank_q, bank_d;
    logic [12:0]   row_q, row_d;
    logic [8:0]    col_q, col_d;
    logic          write_q, write_d;
    logic          ref_expire;

    assign sdram_bank_addr = bank_q;
    assign sdram_row_addr  = row_q;
    assign sdram_col_addr  = col_q;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = (wcnt_q != '0) ? wcnt_q - WW'(1) : '0;
        ret_idle_d    = ret_idle_q;
        bank_d        = bank_q;
        row_d         = row_q;
        col_d         = col_q;
        write_d       = write_q;
        cmd           = CMD_NOP;
        precharge_row = 1'b0;
        precharge_all = 1'b0;
        activate_row  = 1'b0;
        access_done   = 1'b0;
        sdram_ap      = 1'b0;
        req_ready     = 1'b0;

        // Free-running refresh interval timer; a repeat expiry while pending is simply absorbed.
        ref_expire    = (rcnt_q == '0);
        rcnt_d        = ref_expire ? RW'(REFI_CYC - 1) : rcnt_q - RW'(1);
        ref_pending_d = ref_pending_q | ref_expire;

        case (state_q)
            IDLE: begin
                req_ready  = !ref_pending_q;
                ret_idle_d = 1'b0;
                if (ref_pending_q) begin
                    state_d = REF_PREALL;
                end else if (req_valid) begin
                    bank_d  = req_bank;
                    row_d   = req_row;
                    col_d   = req_col;
                    write_d = req_write;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (row_active && row_addr_match) begin
`ifdef SDRAM_AUTO_PRECHARGE_EN
                    if (tras_done) begin
                        cmd           = write_q ? CMD_WRITE : CMD_READ;
                        access_done   = 1'b1;
                        sdram_ap      = 1'b1;
                        precharge_row = 1'b1;
                        ret_idle_d    = 1'b1;
                        wcnt_d        = WW'(RP_CYC - 2);
                        state_d       = TRP_WAIT;
                    end
`else
                    cmd         = write_q ? CMD_WRITE : CMD_READ;
                    access_done = 1'b1;
                    state_d     = IDLE;
`endif
                end else if (row_active) begin
                    if (tras_done) begin
                        cmd           = CMD_PRE;
                        precharge_row = 1'b1;
                        wcnt_d        = WW'(RP_CYC - 2);
                        state_d       = TRP_WAIT;
                    end
                end else if (trc_done) begin
                    cmd          = CMD_ACT;
                    activate_row = 1'b1;
                    wcnt_d       = WW'(RCD_CYC - 2);
                    state_d      = TRCD_WAIT;
                end
            end
            TRP_WAIT: begin
                if (wcnt_q == '0) state_d = ret_idle_q ? IDLE : CHECK;
            end
            TRCD_WAIT: begin
                if (wcnt_q == '0) state_d = CHECK;
            end
            REF_PREALL: begin
                if (tras_all_done) begin
                    cmd           = CMD_PREALL;
                    precharge_all = 1'b1;
                    wcnt_d        = WW'(RP_CYC - 1);
                    state_d       = REF_TRP;
                end
            end
            REF_TRP: begin
                // REFRESH itself lands on the RP_CYC-th cycle after PREALL.
                if (wcnt_q == '0) begin
                    cmd     = CMD_REFRESH;
                    wcnt_d  = WW'(RFC_CYC - 2);
                    state_d = REF_TRFC;
                end
            end
            REF_TRFC: begin
                if (wcnt_q == '0) begin
                    ref_pending_d = ref_expire;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            rcnt_q        <= RW'(REFI_CYC - 1);
            ref_pending_q <= 1'b1;
            ret_idle_q    <= 1'b0;
            bank_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            write_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            ref_pending_q <= ref_pending_d;
            ret_idle_q    <= ret_idle_d;
            bank_q        <= bank_d;
            row_q         <= row_d;
            col_q         <= col_d;
            write_q       <= write_d;
        end
    end
endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Scoreboard bench for sdram_cmd_sched: expected commands are queued with their
// cycle number as stimulus is applied and compared when the DUT issues them.
module tb_sdram_cmd_sched;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, PREALL = 3'd3,
                           RD = 3'd4, WR = 3'd5, REF = 3'd6;
`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [8:0]  req_col;
    logic        row_active, row_addr_match, tras_done, tras_all_done, trc_done;
    logic [1:0]  sdram_bank_addr;
    logic [12:0] sdram_row_addr;
    logic [8:0]  sdram_col_addr;
    logic        sdram_ap, precharge_row, precharge_all, activate_row, access_done;
    logic [2:0]  cmd;

    sdram_cmd_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank),
        .req_row(req_row), .req_col(req_col), .req_write(req_write),
        .row_active(row_active), .row_addr_match(row_addr_match),
        .tras_done(tras_done), .tras_all_done(tras_all_done), .trc_done(trc_done),
        .sdram_bank_addr(sdram_bank_addr), .sdram_row_addr(sdram_row_addr),
        .sdram_col_addr(sdram_col_addr), .sdram_ap(sdram_ap), .cmd(cmd),
        .precharge_row(precharge_row), .precharge_all(precharge_all),
        .activate_row(activate_row), .access_done(access_done)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int n_chk = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_pulses(input logic [2:0] c);
        case (c)
            ACT:     return 4'b0010;
            PRE:     return 4'b1000;
            PREALL:  return 4'b0100;
            RD, WR:  return {AP, 2'b00, 1'b1};
            default: return 4'b0000;
        endcase
    endfunction

    task automatic push(input int c, input logic [2:0] k, input logic [1:0] b,
                        input logic [12:0] r, input logic [8:0] col);
        exp_t e;
        e.cyc = c; e.cmd = k; e.bank = b; e.row = r; e.col = col;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic req(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c, input logic w);
        req_valid = 1'b1; req_bank = b; req_row = r; req_col = c; req_write = w;
    endtask

    // Monitor: every issued command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd != NOP) begin
                if (sbq.size() == 0) begin
                    check_val("unexpected_cmd", 32'(cmd), 32'(NOP));
                end else begin
                    mon_e = sbq.pop_front();
                    check_val("cmd", 32'(cmd), 32'(mon_e.cmd));
                    check_val("cmd_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check_val("pulses", 32'({precharge_row, precharge_all, activate_row, access_done}),
                              32'(exp_pulses(mon_e.cmd)));
                    check_val("ap", 32'(sdram_ap), 32'((mon_e.cmd == RD || mon_e.cmd == WR) ? AP : 1'b0));
                    if (mon_e.cmd == ACT || mon_e.cmd == PRE || mon_e.cmd == RD || mon_e.cmd == WR)
                        check_val("bank", 32'(sdram_bank_addr), 32'(mon_e.bank));
                    if (mon_e.cmd == ACT)
                        check_val("row", 32'(sdram_row_addr), 32'(mon_e.row));
                    if (mon_e.cmd == RD || mon_e.cmd == WR)
                        check_val("col", 32'(sdram_col_addr), 32'(mon_e.col));
                end
            end else begin
                check_val("nop_pulses", 32'({precharge_row, precharge_all, activate_row, access_done, sdram_ap}), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int p_cyc, r_cyc, rb;

    initial begin
        req_valid = 0; req_bank = 0; req_row = 0; req_col = 0; req_write = 0;
        row_active = 0; row_addr_match = 0; tras_done = 0; tras_all_done = 1; trc_done = 0;

        // Reset state and initial refresh sequence
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_cmd", 32'(cmd), 32'(NOP));
        check_val("rst_ready", 32'(req_ready), 0);
        check_val("rst_pulses", 32'({precharge_row, precharge_all, activate_row, access_done, sdram_ap}), 0);
        check_val("rst_addr", 32'({sdram_bank_addr, sdram_row_addr, sdram_col_addr}), 0);
        push(1, PREALL, 0, 0, 0);
        push(3, REF, 0, 0, 0);
        rst = 0;
        wait_to(9);
        check_val("init_ready_early", 32'(req_ready), 0);
        tick();
        check_val("init_ready", 32'(req_ready), 1);

        // Closed row: ACT then hit READ
        req(2'd1, 13'h0ABC, 9'h055, 1'b0);
        row_active = 0; row_addr_match = 0; trc_done = 1; tras_done = 0;
        push(11, ACT, 2'd1, 13'h0ABC, 9'h055);
        tick();
        req_valid = 0;
        tick();
        row_active = 1; row_addr_match = 1; tras_done = 1; trc_done = 0;
        push(13, RD, 2'd1, 13'h0ABC, 9'h055);
        wait_to(16);
        check_val("s2_ready", 32'(req_ready), 1);

        // Row conflict with tRAS pending: 3 NOPs, PRE, ACT, WRITE
        req(2'd2, 13'h1234, 9'h1FF, 1'b1);
        row_active = 1; row_addr_match = 0; tras_done = 0;
        tick();
        req_valid = 0;
        wait_to(20);
        tras_done = 1;
        push(20, PRE, 2'd2, 13'h1234, 9'h1FF);
        tick();
        row_active = 0; trc_done = 1;
        push(22, ACT, 2'd2, 13'h1234, 9'h1FF);
        wait_to(23);
        row_active = 1; row_addr_match = 1; trc_done = 0;
        push(24, WR, 2'd2, 13'h1234, 9'h1FF);
        wait_to(25);
        check_val("s3_ready_next", 32'(req_ready), 32'(!AP));
        tick();
        check_val("s3_ready_after", 32'(req_ready), 1);

        // Hit with tRAS not yet elapsed: closed-page waits, open-page issues at once
        req(2'd0, 13'h0042, 9'h003, 1'b0);
        tras_done = 0;
        push(AP ? 28 : 27, RD, 2'd0, 13'h0042, 9'h003);
        tick();
        req_valid = 0;
        tick();
        tras_done = 1;
        wait_to(30);
        check_val("s6_ready", 32'(req_ready), 1);

        // Refresh expiry while the access sits in TRCD_WAIT
        wait_to(32);
        req(2'd3, 13'h1FFF, 9'h000, 1'b0);
        row_active = 0; row_addr_match = 0; trc_done = 0; tras_done = 0;
        tick();
        req_valid = 0;
        wait_to(778);
        trc_done = 1;
        push(778, ACT, 2'd3, 13'h1FFF, 9'h000);
        tick();
        row_active = 1; row_addr_match = 1; tras_done = 1; trc_done = 0;
        push(780, RD, 2'd3, 13'h1FFF, 9'h000);
        wait_to(781);
        check_val("s4_ready_blocked", 32'(req_ready), 0);
        p_cyc = AP ? 783 : 782;
        r_cyc = p_cyc + 9;
        req(2'd0, 13'h0005, 9'h007, 1'b0);
        push(p_cyc, PREALL, 0, 0, 0);
        push(p_cyc + 2, REF, 0, 0, 0);
        push(r_cyc + 1, RD, 2'd0, 13'h0005, 9'h007);
        wait_to(r_cyc - 1);
        check_val("s4_ready_early", 32'(req_ready), 0);
        tick();
        check_val("s4_ready", 32'(req_ready), 1);
        tick();
        req_valid = 0;

        // Asynchronous reset while in TRCD_WAIT
        rb = r_cyc + 4;
        wait_to(rb);
        req(2'd1, 13'h0777, 9'h011, 1'b0);
        row_active = 0; row_addr_match = 0; trc_done = 1;
        push(rb + 1, ACT, 2'd1, 13'h0777, 9'h011);
        tick();
        req_valid = 0;
        tick();
        #2;
        rst = 1;
        #1;
        check_val("arst_cmd", 32'(cmd), 32'(NOP));
        check_val("arst_pulses", 32'({precharge_row, precharge_all, activate_row, access_done, sdram_ap}), 0);
        check_val("arst_addr", 32'({sdram_bank_addr, sdram_row_addr, sdram_col_addr}), 0);
        check_val("arst_ready", 32'(req_ready), 0);
        trc_done = 0;
        repeat (2) @(posedge clk);
        #2;
        push(1, PREALL, 0, 0, 0);
        push(3, REF, 0, 0, 0);
        rst = 0;
        wait_to(9);
        check_val("rerst_ready_early", 32'(req_ready), 0);
        tick();
        check_val("rerst_ready", 32'(req_ready), 1);
        repeat (3) tick();
        check_val("sb_empty", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
